// File: rtl/mips_mc_core_if.sv
// Instruction-offer handshake between a fetch source and mips_mc_core.
// master drives instr_valid/instr; slave returns instr_ready.
interface mips_mc_core_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS subset core (R add/sub/and/or/slt, lw, sw, beq, j, addi).
// Ports: clk, rst_n (async, active-low), ibus (instr offer, slave modport),
// class_o, done, illegal, wb_en/wb_addr/wb_data (write-back view), pc_o.
// Build option: define MIPS_MC_OVF_TRAP_EN to trap signed overflow on
// add/sub/addi (illegal in done cycle, write-back suppressed).
module mips_mc_core #(
    parameter int DW         = 32,
    parameter int NREG       = 32,
    parameter int DMEM_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_mc_core_if.slave       ibus,
    output logic [2:0]          class_o,
    output logic                done,
    output logic                illegal,
    output logic                wb_en,
    output logic [4:0]          wb_addr,
    output logic [DW-1:0]       wb_data,
    output logic [DW-1:0]       pc_o
);
    localparam int AW = $clog2(NREG);
    localparam int MW = $clog2(DMEM_DEPTH);

    localparam logic [2:0] C_R    = 3'b001;
    localparam logic [2:0] C_LW   = 3'b010;
    localparam logic [2:0] C_SW   = 3'b011;
    localparam logic [2:0] C_BEQ  = 3'b100;
    localparam logic [2:0] C_J    = 3'b101;
    localparam logic [2:0] C_ADDI = 3'b110;
    localparam logic [2:0] C_ILL  = 3'b111;

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        DEC  = 5'b00010,
        EX   = 5'b00100,
        MEM  = 5'b01000,
        WB   = 5'b10000
    } state_t;

    state_t st, st_n;

    logic [31:0]   ir;
    logic [2:0]    cls_q;
    logic [DW-1:0] opa, opb;
    logic [DW-1:0] res_q;
    logic [DW-1:0] mdr;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] rf   [NREG];
    logic [DW-1:0] dmem [DMEM_DEPTH];

    logic [5:0]    op, fn;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] sext;

    assign op   = ir[31:26];
    assign fn   = ir[5:0];
    assign rs   = ir[21 +: AW];
    assign rt   = ir[16 +: AW];
    assign rd   = ir[11 +: AW];
    assign sext = {{(DW-16){ir[15]}}, ir[15:0]};

    logic unused_bits;
    assign unused_bits = ^ir[10:6];

    // ---------------- decode (valid while in DEC) ----------------
    logic [2:0] dec_cls;

    always_comb begin
        dec_cls = C_ILL;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24,
                    6'h25, 6'h2A: dec_cls = C_R;
                    default:      dec_cls = C_ILL;
                endcase
            end
            6'h23:   dec_cls = C_LW;
            6'h2B:   dec_cls = C_SW;
            6'h04:   dec_cls = C_BEQ;
            6'h02:   dec_cls = C_J;
            6'h08:   dec_cls = C_ADDI;
            default: dec_cls = C_ILL;
        endcase
    end

    // ---------------- ALU (valid while in EX) ----------------
    logic [DW-1:0] sum, dif, sumi, alu;
    logic          ovf;
    logic          msb_a;

    assign sum   = opa + opb;
    assign dif   = opa - opb;
    assign sumi  = opa + sext;
    assign msb_a = opa[DW-1];

    always_comb begin
        alu = sumi;
        ovf = 1'b0;
        if (cls_q == C_R) begin
            case (fn)
                6'h20: begin
                    alu = sum;
                    ovf = (msb_a == opb[DW-1]) &&
                          (sum[DW-1] != msb_a);
                end
                6'h22: begin
                    alu = dif;
                    ovf = (msb_a != opb[DW-1]) &&
                          (dif[DW-1] != msb_a);
                end
                6'h24:   alu = opa & opb;
                6'h25:   alu = opa | opb;
                6'h2A:   alu = DW'($signed(opa) < $signed(opb));
                default: alu = '0;
            endcase
        end else if (cls_q == C_ADDI) begin
            ovf = (msb_a == sext[DW-1]) &&
                  (sumi[DW-1] != msb_a);
        end
    end

    logic trap;

`ifdef MIPS_MC_OVF_TRAP_EN
    logic ovf_q;
    assign trap = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
    assign trap = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_n;
    end

    always_comb begin
        st_n = st;
        unique case (st)
            IDLE: if (ibus.instr_valid) st_n = DEC;
            DEC:  st_n = EX;
            EX: begin
                if (cls_q == C_BEQ || cls_q == C_J ||
                    cls_q == C_ILL)
                    st_n = IDLE;
                else if (cls_q == C_LW || cls_q == C_SW)
                    st_n = MEM;
                else
                    st_n = WB;
            end
            MEM:     st_n = (cls_q == C_LW) ? WB : IDLE;
            WB:      st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    logic [AW-1:0] wb_dst;
    logic [DW-1:0] pc4, pc_nxt;
    logic          in_wb;

    assign in_wb  = (st == WB);
    assign wb_dst = (cls_q == C_R) ? rd : rt;
    assign pc4    = pc_q + DW'(4);

    always_comb begin
        pc_nxt = pc4;
        if (cls_q == C_ILL)
            pc_nxt = pc_q;
        else if (cls_q == C_BEQ && opa == opb)
            pc_nxt = pc4 + {sext[DW-3:0], 2'b00};
        else if (cls_q == C_J)
            pc_nxt = {pc4[DW-1:28], ir[25:0], 2'b00};
    end

    assign ibus.instr_ready = (st == IDLE);

    // Class is live from DEC, then held until the next acceptance.
    assign class_o = (st == DEC) ? dec_cls : cls_q;

    assign done = in_wb ||
                  (st == MEM && cls_q == C_SW) ||
                  (st == EX && (cls_q == C_BEQ ||
                                cls_q == C_J   ||
                                cls_q == C_ILL));

    assign illegal = (st == EX && cls_q == C_ILL) ||
                     (in_wb && trap);

    assign wb_en   = in_wb && !trap;
    assign wb_addr = wb_en ? 5'(wb_dst) : 5'd0;
    assign wb_data = !wb_en ? '0 :
                     (cls_q == C_LW) ? mdr : res_q;

    // New PC is visible during the done cycle and latched at its end.
    assign pc_o = done ? pc_nxt : pc_q;

    // ---------------- datapath state ----------------
    logic [MW-1:0] idx;
    assign idx = res_q[2 +: MW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir    <= '0;
            cls_q <= '0;
            opa   <= '0;
            opb   <= '0;
            res_q <= '0;
            mdr   <= '0;
            pc_q  <= '0;
`ifdef MIPS_MC_OVF_TRAP_EN
            ovf_q <= 1'b0;
`endif
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++)
                dmem[i] <= '0;
        end else begin
            if (st == IDLE && ibus.instr_valid)
                ir <= ibus.instr;
            if (st == DEC) begin
                cls_q <= dec_cls;
                opa   <= rf[rs];
                opb   <= rf[rt];
            end
            if (st == EX) begin
                res_q <= alu;
`ifdef MIPS_MC_OVF_TRAP_EN
                ovf_q <= ovf;
`endif
            end
            if (st == MEM) begin
                if (cls_q == C_SW) dmem[idx] <= opb;
                else               mdr       <= dmem[idx];
            end
            // Register 0 stays zero: writes to it are dropped.
            if (wb_en && wb_dst != '0)
                rf[wb_dst] <= wb_data;
            if (done)
                pc_q <= pc_nxt;
        end
    end
endmodule

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 SHALL have parameter DW, default 32: datapath/register width, legal range 32..64.
REQ-002 SHALL have parameter NREG, default 32: register count, power of two in 8..32; rs/rt/rd use the low log2(NREG) bits.
REQ-003 SHALL have parameter DMEM_DEPTH, default 16: words of internal data memory, power of two.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports instr_valid (input, 1) and instr (input, 32): instruction offer, MIPS encoding.
REQ-007 SHALL have port instr_ready, output, 1: core can accept an instruction.
REQ-008 SHALL have port class_o, output, 3: class of the instruction in flight.
- Encoding: R=001, lw=010, sw=011, beq=100, j=101, addi=110, illegal=111.
REQ-009 SHALL have ports done (output, 1) and illegal (output, 1): completion pulse and fault flag.
REQ-010 SHALL have ports wb_en (output, 1), wb_addr (output, 5) and wb_data (output, DW): register-write observation.
REQ-011 SHALL have port pc_o, output, DW: current program counter.

Function
REQ-012 SHALL run a one-hot FSM with states IDLE, DEC, EX, MEM, WB.
- instr_ready=1 only in IDLE.
- The instruction is captured on the clk edge where instr_valid&instr_ready=1; the next state is DEC.
REQ-013 SHALL take these paths, accept edge = cycle 0, done high in the last listed state:
- R-type add/sub/and/or/slt (funct 20/22/24/25/2A) and addi: DEC, EX, WB (done in cycle 3).
- lw: DEC, EX, MEM, WB (done in cycle 4).
- sw: DEC, EX, MEM (done in cycle 3).
- beq, j: DEC, EX (done in cycle 2).
- After the done cycle the FSM returns to IDLE.
REQ-014 SHALL pulse done for exactly one cycle per accepted instruction.
REQ-015 SHALL decode the class in DEC and hold class_o until the next acceptance.
REQ-016 SHALL treat any other opcode or funct as illegal:
- class_o=111, illegal=1 in EX, done in EX.
- No register, memory or PC change.
REQ-017 SHALL sign-extend imm16 to DW bits.
- Arithmetic is modulo 2^DW.
- slt is a signed compare, result 0 or 1.
REQ-018 SHALL make register 0 read as zero and silently drop writes to it.
- wb_en still pulses when the destination is 0.
REQ-019 SHALL assert wb_en for one cycle in WB, with wb_addr = destination (rd for R-type, rt for lw/addi) and wb_data = written value.
- wb_en, wb_addr and wb_data are zero otherwise.
REQ-020 SHALL compute the memory word index as ((rs+sext(imm))>>2) mod DMEM_DEPTH, so the index wraps.
- sw writes rt to that index in MEM.
- lw reads it in MEM.
REQ-021 SHALL update pc_o in the done cycle:
- beq taken: pc+4+(sext(imm)<<2).
- j: {pc+4 upper DW-28 bits, target26, 2'b00}.
- Otherwise: pc+4.
- Illegal leaves pc_o unchanged.
REQ-022 SHALL read source registers in DEC.
- A write-back completing in the previous instruction's WB is visible; no hazard exists because issue is serial.
REQ-023 SHALL ignore instr_valid outside IDLE; the instr value is don't-care there.

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk:
- Force state IDLE.
- Clear all registers, data memory and pc_o to 0.
- Drive instr_ready=1, class_o=000, done=0, illegal=0, wb_en=0, wb_addr=0, wb_data=0.
REQ-025 SHALL abandon any in-flight instruction when reset asserts mid-operation, with no partial write surviving.

Configuration
REQ-026 SHALL, with macro MIPS_MC_OVF_TRAP_EN defined, detect signed overflow on add, sub and addi:
- illegal=1 in the done cycle.
- Writeback suppressed (wb_en=0).
- done still pulses.
- pc advances by 4.
REQ-027 SHALL, without MIPS_MC_OVF_TRAP_EN, wrap the result and write it back; illegal then arises only from REQ-016.

Verification
REQ-028 SHALL cover addi $17,$0,10 then addi $18,$0,20 then 0x02328020 (add $16,$17,$18):
- Third instruction: class_o=001.
- Cycle 3: done=1, wb_en=1, wb_addr=16, wb_data=30.
- pc_o ends at 12.
REQ-029 SHALL cover sw $18,32($17) ($17=10, $18=20) then lw $16,32($17):
- sw: done in cycle 3, class_o=011.
- lw: cycle 4 gives wb_addr=16, wb_data=20.
- Word index 10 (42>>2), mod 16.
REQ-030 SHALL cover beq $16,$17,50 with equal operands:
- done in cycle 2, class_o=100.
- pc_o = old pc+4+200.
- Unequal operands give pc+4.
REQ-031 SHALL cover j 1000 from pc=0:
- done in cycle 2, class_o=101, pc_o=4000, no wb_en.
REQ-032 SHALL cover opcode 111111:
- class_o=111, illegal=1, done in cycle 2, pc_o unchanged.
REQ-033 SHALL cover rst_n low during the EX cycle of an add:
- Outputs at reset values immediately; no wb_en.
- After release, a fresh addi $1,$0,1 completes in cycle 3 with wb_data=1.
- With MIPS_MC_OVF_TRAP_EN: 0x7FFFFFFF+1 gives illegal=1, wb_en=0.
